mem_lsu: RTL and testbench
==========================

# mem_lsu

MEM stage with a registered data-bus master for loads and stores. It consumes the EX/MEM register outputs and runs one bus transaction per load/store on a valid/acknowledge data bus. It raises `stallreq` to the stall controller until that transaction completes, then presents the write-back result to the MEM/WB register. Non-memory instructions pass straight through in zero cycles.

## Interface
Parameters
- `ADDR_W`, 32, data bus address width.
- `BUS_BE`, 1, byte-lane order on the bus; 1 = big-endian, so byte address 00 is bits 31:24.

Ports
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous reset, active-low.
- `stall`  in  6  stall vector from the stall controller; bit 4 = MEM/WB hold.
- `wd_i`, `wreg_i`, `wdata_i`  in  5/1/32  destination register, write enable, ALU result.
- `whilo_i`, `hi_i`, `lo_i`  in  1/32/32  HI/LO write enable and values.
- `aluop_i`  in  8  operation code; memory codes are LB, LBU, LH, LHU, LW, SB, SH, SW.
- `mem_addr_i`  in  32  effective address.
- `reg2_i`  in  32  store data.
- `wd_o`, `wreg_o`, `wdata_o`, `whilo_o`, `hi_o`, `lo_o`  out  same widths as the inputs  result to MEM/WB.
- `stallreq`  out  1  request to stall stages 0–4.
- `bus_cyc`, `bus_we`  out  1/1  transaction valid, write.
- `bus_addr`  out  `ADDR_W`  word-aligned address: `mem_addr_i` with the low 2 bits forced to 00.
- `bus_sel`  out  4  byte enables.
- `bus_wdata`  out  32  store data, replicated onto the active lanes.
- `bus_rdata`  in  32  load data.
- `bus_ack`  in  1  transaction complete; sampled only while `bus_cyc`=1.

## Operation
FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - Non-memory op: outputs equal the inputs combinationally; `stallreq`=0.
  - Memory op: `stallreq`=1 combinationally and WB outputs are NOP (`wreg_o`=0, `whilo_o`=0, data 0).
  - On the next edge: latch the bus signals, assert `bus_cyc`, go to BUSY.
- **BUSY**
  - Hold all bus outputs stable; `stallreq`=1; WB outputs NOP.
  - On an edge with `bus_ack`=1: capture `bus_rdata` into `ld_buf`, drop `bus_cyc`, go to DONE.
  - There is no timeout.
- **DONE**
  - `stallreq`=0.
  - Load: `wdata_o` is the lane-extracted, extended `ld_buf`; `wd_o`/`wreg_o` pass through.
  - Store: `wreg_o`=0.
  - Go to IDLE on an edge where `stall[4]`=0; otherwise stay in DONE holding the result.

Lane rules (big-endian), with `a` = `mem_addr_i[1:0]`:
- Byte ops: `bus_sel` = 1000 >> `a`; the byte is taken from that lane.
- Halfword ops: `a[1]`=0 gives sel 1100, 1 gives sel 0011. `a[0]` is ignored; no alignment exception.
- Word ops: sel 1111; `a` is ignored.
- LB/LH sign-extend; LBU/LHU zero-extend.
- SB writes `{4{reg2[7:0]}}`; SH writes `{2{reg2[15:0]}}`.

Boundary behaviour:
- `bus_ack` in IDLE or DONE: ignored.
- Reset asserted mid-transaction: state returns to IDLE, `bus_cyc` drops immediately (asynchronous), `ld_buf` clears; the pending instruction is dropped.
- HI/LO signals pass through unchanged in every state except the NOP cases.

## Timing
- Reset values:
  - State IDLE.
  - `bus_cyc`=0, `bus_we`=0, `bus_addr`=0, `bus_sel`=0, `bus_wdata`=0, `ld_buf`=0.
  - `stallreq`=0.
  - WB outputs: `wd_o`=0 (NOP register), `wreg_o`=0, `wdata_o`=0, `whilo_o`=0, `hi_o`=0, `lo_o`=0.
- Memory-op latency:
  - Cycle 0: IDLE.
  - Cycle 1: BUSY, `bus_cyc`=1.
  - Ack sampled at the end of cycle k.
  - Cycle k+1: DONE.
- With a zero-wait ack the minimum is 3 cycles, and `stallreq` is high for exactly 2.
- Bus outputs are registered. WB outputs and `stallreq` are combinational from state and inputs.

## Structure
- Shared defines package: the 8-bit memory aluop codes, `ZeroWord`, `NOPRegAddr`, `WriteEnable`/`WriteDisable`, `Stop`/`NoStop`, and the 2-bit state encoding.
- One natural sub-module: `mem_lane_align`. It is combinational and produces `bus_sel`/`bus_wdata` from op/addr/data, and the extended load word from op/addr/`ld_buf`.
- `mem_lsu` holds the FSM, the bus registers and the WB output mux.

## Test plan
- ADDU result 0x1234, `wd`=5, `wreg`=1 → same cycle: `wdata_o`=0x1234, `wreg_o`=1, `stallreq`=0, `bus_cyc` stays 0.
- LB from addr 0x103, `bus_rdata`=0x000000F0, ack in the first BUSY cycle:
  - `bus_addr`=0x100, `bus_sel`=0001.
  - `stallreq` high for 2 cycles.
  - DONE: `wdata_o`=0xFFFFFFF0, `wreg_o`=1.
- SH addr 0x202, `reg2`=0xAAAA5678, ack delayed 3 cycles:
  - `bus_we`=1, `bus_sel`=0011, `bus_wdata`=0x56785678, bus outputs stable while waiting.
  - `stallreq` high for 5 cycles.
  - DONE: `wreg_o`=0.
- LHU addr 0x300, `bus_rdata`=0x8001FFFF, with `stall[4]`=1 for 2 cycles after DONE → DONE held 3 cycles with `wdata_o`=0x00008001, then IDLE.
- `rst` pulsed low mid-BUSY → `bus_cyc` falls the same cycle; state IDLE; a later ack is ignored.
- `bus_ack`=1 held while IDLE with a non-memory op → no state change, no capture.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM stage: memory aluop codes, write-back constants
// and the load/store unit state encoding.
package mem_lsu_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Byte-lane steering between the 32-bit data bus and the register file:
// store enables/data replication and load lane extraction with extension.
module mem_lane_align
    import mem_lsu_pkg::*;
#(
    parameter int BUS_BE = 1
) (
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_buf_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    // Lane index 0 is bits 7:0; big-endian puts byte address 00 on lane 3.
    logic [1:0]  byte_lane;
    logic [1:0]  half_lane;
    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;

    always_comb begin
        byte_lane    = (BUS_BE != 0) ? (2'd3 - addr_i) : addr_i;
        half_lane    = (BUS_BE != 0) ? {~addr_i[1], 1'b0} : {addr_i[1], 1'b0};
        byte_shifted = ld_buf_i >> {byte_lane, 3'b000};
        half_shifted = ld_buf_i >> {half_lane, 3'b000};

        sel_o     = 4'b0000;
        wdata_o   = ZeroWord;
        ld_data_o = ZeroWord;
        case (aluop_i)
            EXE_LB_OP: begin
                sel_o     = 4'b0001 << byte_lane;
                ld_data_o = {{24{byte_shifted[7]}}, byte_shifted[7:0]};
            end
            EXE_LBU_OP: begin
                sel_o     = 4'b0001 << byte_lane;
                ld_data_o = {24'h000000, byte_shifted[7:0]};
            end
            EXE_LH_OP: begin
                sel_o     = 4'b0011 << half_lane;
                ld_data_o = {{16{half_shifted[15]}}, half_shifted[15:0]};
            end
            EXE_LHU_OP: begin
                sel_o     = 4'b0011 << half_lane;
                ld_data_o = {16'h0000, half_shifted[15:0]};
            end
            EXE_LW_OP: begin
                sel_o     = 4'b1111;
                ld_data_o = ld_buf_i;
            end
            EXE_SB_OP: begin
                sel_o   = 4'b0001 << byte_lane;
                wdata_o = {4{st_data_i[7:0]}};
            end
            EXE_SH_OP: begin
                sel_o   = 4'b0011 << half_lane;
                wdata_o = {2{st_data_i[15:0]}};
            end
            EXE_SW_OP: begin
                sel_o   = 4'b1111;
                wdata_o = st_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage load/store unit: one registered bus transaction per memory op,
// stalling the pipeline until the acknowledge, then presenting the write-back.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BUS_BE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic              whilo_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              whilo_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              stallreq,
    output logic              bus_cyc,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic [1:0]        state_o
);

    lsu_state_e        state_q, state_d;
    logic              bus_cyc_q, bus_cyc_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       ld_buf_q, ld_buf_d;

    logic        ld_op, st_op, mem_op;
    logic [3:0]  sel_c;
    logic [31:0] st_data_c;
    logic [31:0] ld_ext_c;

    assign ld_op  = is_load_op(aluop_i);
    assign st_op  = is_store_op(aluop_i);
    assign mem_op = ld_op | st_op;

    mem_lane_align #(.BUS_BE(BUS_BE)) u_align (
        .aluop_i   (aluop_i),
        .addr_i    (mem_addr_i[1:0]),
        .st_data_i (reg2_i),
        .ld_buf_i  (ld_buf_q),
        .sel_o     (sel_c),
        .wdata_o   (st_data_c),
        .ld_data_o (ld_ext_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= 4'b0000;
            bus_wdata_q <= ZeroWord;
            ld_buf_q    <= ZeroWord;
        end else begin
            state_q     <= state_d;
            bus_cyc_q   <= bus_cyc_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            ld_buf_q    <= ld_buf_d;
        end
    end

    // Bus request is launched from IDLE and held untouched until the ack edge.
    always_comb begin
        state_d     = state_q;
        bus_cyc_d   = bus_cyc_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        ld_buf_d    = ld_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    state_d     = ST_BUSY;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = st_op ? WriteEnable : WriteDisable;
                    bus_addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                    bus_sel_d   = sel_c;
                    bus_wdata_d = st_data_c;
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    state_d   = ST_DONE;
                    bus_cyc_d = 1'b0;
                    ld_buf_d  = bus_rdata;
                end
            end
            ST_DONE: begin
                if (!stall[4]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wd_o     = wd_i;
        wreg_o   = wreg_i;
        wdata_o  = wdata_i;
        whilo_o  = whilo_i;
        hi_o     = hi_i;
        lo_o     = lo_i;
        stallreq = NoStop;
        if ((state_q == ST_BUSY) || ((state_q == ST_IDLE) && mem_op)) begin
            stallreq = Stop;
            wd_o     = NOPRegAddr;
            wreg_o   = WriteDisable;
            wdata_o  = ZeroWord;
            whilo_o  = WriteDisable;
            hi_o     = ZeroWord;
            lo_o     = ZeroWord;
        end else if (state_q == ST_DONE) begin
            if (ld_op) wdata_o = ld_ext_c;
            if (st_op) wreg_o  = WriteDisable;
        end
    end

    assign bus_cyc   = bus_cyc_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, load/store lane handling, ack
// latency, result hold under stall, and asynchronous reset mid-transaction.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        whilo_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq;
    logic        bus_cyc;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    mem_lsu #(.ADDR_W(32), .BUS_BE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .whilo_i    (whilo_i),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .aluop_i    (aluop_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq   (stallreq),
        .bus_cyc    (bus_cyc),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_sel    (bus_sel),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with stallreq high, sampled mid-cycle.
    always @(negedge clk) if (stallreq === 1'b1) stall_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] st,
                            input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = st;
        wd_i       = wd;
        wreg_i     = wreg;
        wdata_i    = wdata;
    endtask

    task automatic drive_nop();
        drive_op(8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        whilo_i = 1'b0;
        hi_i    = 32'h0;
        lo_i    = 32'h0;
    endtask

    initial begin
        rst       = 1'b0;
        stall     = 6'b0;
        bus_rdata = 32'h0;
        bus_ack   = 1'b0;
        drive_nop();
        step();
        step();

        // Reset state
        chk("rst_state", state_o, S_IDLE);
        chk("rst_bus_cyc", bus_cyc, 1'b0);
        chk("rst_bus_we", bus_we, 1'b0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_sel", bus_sel, 4'b0000);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_stallreq", stallreq, 1'b0);
        chk("rst_wb", {wd_o, wreg_o, whilo_o}, 7'h0);
        rst = 1'b1;
        step();

        // Non-memory op passes straight through in the same cycle
        drive_op(OP_ADDU, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234);
        whilo_i = 1'b1;
        hi_i    = 32'hCAFE_0001;
        lo_i    = 32'hBEEF_0002;
        #1;
        chk("addu_wdata", wdata_o, 32'h0000_1234);
        chk("addu_wreg", wreg_o, 1'b1);
        chk("addu_wd", wd_o, 5'd5);
        chk("addu_stallreq", stallreq, 1'b0);
        chk("addu_hi", hi_o, 32'hCAFE_0001);
        chk("addu_lo", lo_o, 32'hBEEF_0002);
        step();
        chk("addu_bus_cyc", bus_cyc, 1'b0);
        chk("addu_state", state_o, S_IDLE);
        drive_nop();

        // LB from 0x103, zero-wait ack
        stall_cnt = 0;
        drive_op(EXE_LB_OP, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 32'h0000_0103);
        bus_rdata = 32'h0000_00F0;
        #1;
        chk("lb_idle_stallreq", stallreq, 1'b1);
        chk("lb_idle_nop_wreg", wreg_o, 1'b0);
        chk("lb_idle_nop_wdata", wdata_o, 32'h0);
        step();
        chk("lb_busy_state", state_o, S_BUSY);
        chk("lb_bus_cyc", bus_cyc, 1'b1);
        chk("lb_bus_we", bus_we, 1'b0);
        chk("lb_bus_addr", bus_addr, 32'h0000_0100);
        chk("lb_bus_sel", bus_sel, 4'b0001);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        chk("lb_done_state", state_o, S_DONE);
        chk("lb_done_stallreq", stallreq, 1'b0);
        chk("lb_done_bus_cyc", bus_cyc, 1'b0);
        chk("lb_done_wdata", wdata_o, 32'hFFFF_FFF0);
        chk("lb_done_wreg", wreg_o, 1'b1);
        chk("lb_done_wd", wd_o, 5'd7);
        step();
        drive_nop();
        chk("lb_back_idle", state_o, S_IDLE);
        chk("lb_stall_cycles", stall_cnt, 32'd2);

        // SH to 0x202 with the ack arriving on the fourth BUSY cycle
        stall_cnt = 0;
        drive_op(EXE_SH_OP, 32'h0000_0202, 32'hAAAA_5678, 5'd9, 1'b1, 32'h0000_0202);
        step();
        chk("sh_bus_we", bus_we, 1'b1);
        chk("sh_bus_addr", bus_addr, 32'h0000_0200);
        chk("sh_bus_sel", bus_sel, 4'b0011);
        chk("sh_bus_wdata", bus_wdata, 32'h5678_5678);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sh_wait_state", state_o, S_BUSY);
            chk("sh_wait_cyc", bus_cyc, 1'b1);
            chk("sh_wait_sel", bus_sel, 4'b0011);
            chk("sh_wait_wdata", bus_wdata, 32'h5678_5678);
            chk("sh_wait_stallreq", stallreq, 1'b1);
        end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        chk("sh_done_state", state_o, S_DONE);
        chk("sh_done_wreg", wreg_o, 1'b0);
        chk("sh_done_stallreq", stallreq, 1'b0);
        step();
        drive_nop();
        chk("sh_back_idle", state_o, S_IDLE);
        chk("sh_stall_cycles", stall_cnt, 32'd5);

        // LHU from 0x300, result held while MEM/WB is stalled
        drive_op(EXE_LHU_OP, 32'h0000_0300, 32'h0, 5'd3, 1'b1, 32'h0000_0300);
        bus_rdata = 32'h8001_FFFF;
        step();
        chk("lhu_bus_sel", bus_sel, 4'b1100);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        stall   = 6'b01_0000;
        chk("lhu_done1_state", state_o, S_DONE);
        chk("lhu_done1_wdata", wdata_o, 32'h0000_8001);
        // A stray ack with different data while in DONE must not recapture.
        bus_rdata = 32'h0000_0000;
        bus_ack   = 1'b1;
        step();
        bus_ack = 1'b0;
        chk("lhu_done2_state", state_o, S_DONE);
        chk("lhu_done2_wdata", wdata_o, 32'h0000_8001);
        step();
        chk("lhu_done3_state", state_o, S_DONE);
        chk("lhu_done3_wdata", wdata_o, 32'h0000_8001);
        chk("lhu_done3_stallreq", stallreq, 1'b0);
        stall = 6'b0;
        step();
        drive_nop();
        chk("lhu_back_idle", state_o, S_IDLE);

        // Asynchronous reset in the middle of a BUSY wait
        drive_op(EXE_LW_OP, 32'h0000_0404, 32'h0, 5'd4, 1'b1, 32'h0);
        bus_rdata = 32'h1122_3344;
        step();
        chk("rstmid_busy_cyc", bus_cyc, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_cyc_drop", bus_cyc, 1'b0);
        chk("rstmid_state", state_o, S_IDLE);
        drive_nop();
        bus_ack = 1'b1;
        #1;
        rst = 1'b1;
        step();
        chk("rstmid_ack_ignored_state", state_o, S_IDLE);
        chk("rstmid_ack_ignored_cyc", bus_cyc, 1'b0);

        // Ack held high while IDLE with a non-memory op
        drive_op(OP_ADDU, 32'h0, 32'h0, 5'd12, 1'b1, 32'h0000_00AB);
        bus_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_ack_state", state_o, S_IDLE);
            chk("idle_ack_cyc", bus_cyc, 1'b0);
            chk("idle_ack_wdata", wdata_o, 32'h0000_00AB);
        end
        bus_ack = 1'b0;
        drive_nop();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
